dac_sample_feeder: RTL and testbench
====================================

// Module: dac_sample_feeder
// PURPOSE
//  Upstream pacing stage for the DACx811 serial driver. Buffers samples from a valid/ready stream in a FIFO.
//  Issues exactly one start+data transaction to the driver per sample period.
//  Flags underruns (FIFO empty at a tick) and late ticks (driver still busy), so waveform playback has a fixed, known rate.
// PARAMETERS
//  BITS               16    sample width; matches the driver (16 = 8811, 12 = 7811)
//  DEPTH              16    FIFO entries; power of two, >= 2
//  RATE_DIV           1000  clk cycles per sample period; must exceed one full driver frame, >= 2
//  REPEAT_ON_UNDERRUN 1     1: re-send last sample on underrun; 0: skip the frame
// PORTS
//  clk           in   1                  clock
//  rst           in   1                  synchronous, active-high reset
//  en            in   1                  enable sample timer; low = paused
//  s_data        in   BITS               input sample
//  s_valid       in   1                  s_data valid
//  s_ready       out  1                  FIFO can accept (= ~full)
//  level         out  $clog2(DEPTH)+1    FIFO occupancy, 0..DEPTH
//  dac_start     out  1                  1-cycle start pulse to driver
//  dac_data      out  BITS               sample to driver; stable from start until next start
//  dac_busy      in   1                  driver busy
//  underrun_cnt  out  16                 saturating count of underrun ticks
//  late          out  1                  sticky: a tick arrived while a frame was still in flight
//  clr_err       in   1                  clears underrun_cnt and late
// BEHAVIOUR
//  Reset values: s_ready=1, level=0, dac_start=0, dac_data=0, underrun_cnt=0, late=0, FSM=IDLE, timer=0.
//  Reset empties the FIFO.
//  Timer: counts 0..RATE_DIV-1 while en, then wraps. tick = en & cnt==RATE_DIV-1. en=0 holds cnt at 0.
//  en falling mid-frame: the in-flight frame completes; FIFO contents are kept.
//  FIFO write: on s_valid & s_ready. At full, s_ready=0 and no write occurs.
//  A write in the tick cycle is not visible to that tick; only level>0 at the tick counts.
//  FSM states:
//   IDLE
//    - tick & dac_busy: set late, drop the tick.
//    - tick & level>0: pop head into dac_data, go START.
//    - tick & level==0: underrun_cnt+1 (sat at 16'hFFFF).
//      If REPEAT_ON_UNDERRUN, go START with dac_data unchanged; else stay IDLE.
//   START: dac_start=1 for exactly this cycle. Go WAIT.
//   WAIT: go IDLE when dac_busy==0. The driver raises busy the cycle after it samples start.
//  tick while in START or WAIT: set late, drop the tick. Exactly one start is issued per accepted tick.
//  Pop and push in the same cycle: level unchanged; data order preserved.
//  clr_err together with a new underrun or late event: the event wins.
//   Result is underrun_cnt=1 or late=1.
//  Reset mid-frame: the feeder returns to IDLE. If the driver is still busy, the next tick is late.
//  dac_start and dac_data are registered outputs, with no combinational path from the inputs.
// STRUCTURE
//  Package dac_feed_pkg:
//   - typedef enum logic[1:0] {IDLE, START, WAIT} feed_state_t
//   - localparam UNDERRUN_MAX = 16'hFFFF
//  Sub-module sync_fifo #(WIDTH, DEPTH):
//   - ports wr_en, wr_data, rd_en, rd_data (head, fall-through), full, empty, level
//   - pointers are $clog2(DEPTH)+1 bits wide
//  Sample timer: instance of the shared Counter with M=RATE_DIV, en=en.
//   Its co output is the tick.
// TESTING (BITS=16, DEPTH=4, RATE_DIV=40, behavioural driver model, busy for 34 cycles)
//  1. Push 16'h1234, 16'hABCD, then en=1.
//     -> dac_start at ticks 1 and 2 carrying 1234 then ABCD, exactly 40 cycles apart.
//  2. Push 5 samples back-to-back.
//     -> s_ready=0 after the 4th; the 5th is held off until the first pop; level never exceeds 4.
//  3. FIFO empty at a tick with REPEAT_ON_UNDERRUN=1.
//     -> start re-sends the last value, underrun_cnt=1. With REPEAT_ON_UNDERRUN=0: no start.
//  4. Driver model busy for 50 cycles.
//     -> the next tick sets late=1, no start on that tick; a pulse on clr_err clears late to 0.
//  5. rst asserted in WAIT with 3 samples queued.
//     -> level=0, dac_start=0, late=0; no further starts until new data arrives.
//  6. Push and pop in the same cycle at level=2.
//     -> level stays 2; output order matches input order.

Source files
------------

// File: rtl/dac_feed_pkg.sv
// ---------------------------------------------------------------------------
// dac_feed_pkg : shared types and constants for the DAC sample feeder
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dac_feed_pkg;
   typedef enum logic [1:0] {IDLE, START, WAIT} feed_state_t;
   localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;
endpackage

`default_nettype wire

// File: rtl/Counter.sv
// ---------------------------------------------------------------------------
// Counter : modulo-M counter, co pulses in the last count of each period
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module Counter #(
   parameter int M = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic co
);
   localparam int W = $clog2(M);
   localparam logic [W-1:0] LAST = W'(M - 1);

   logic [W-1:0] cnt;

   // Disabling the counter parks it at zero so a resumed period is full length.
   always_ff @(posedge clk) begin
      if (rst || !en)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign co = en & (cnt == LAST);
endmodule

`default_nettype wire

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo : single-clock FIFO with fall-through head and occupancy output
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;

   // The extra pointer bit distinguishes full from empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_en && !full)
            wptr <= wptr + 1'b1;
         if (rd_en && !empty)
            rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !full)
         mem[wptr[AW-1:0]] <= wr_data;
   end

   assign level   = wptr - rptr;
   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign rd_data = mem[rptr[AW-1:0]];
endmodule

`default_nettype wire

// File: rtl/dac_sample_feeder.sv
// ---------------------------------------------------------------------------
// dac_sample_feeder : paces FIFO-buffered samples into the DAC serial driver
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dac_sample_feeder
   import dac_feed_pkg::*;
#(
   parameter int BITS               = 16,
   parameter int DEPTH              = 16,
   parameter int RATE_DIV           = 1000,
   parameter int REPEAT_ON_UNDERRUN = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [BITS-1:0]        s_data,
   input  logic                   s_valid,
   output logic                   s_ready,
   output logic [$clog2(DEPTH):0] level,
   output logic                   dac_start,
   output logic [BITS-1:0]        dac_data,
   input  logic                   dac_busy,
   output logic [15:0]            underrun_cnt,
   output logic                   late,
   input  logic                   clr_err
);
   feed_state_t     state;
   logic            tick;
   logic            full;
   logic            empty;
   logic [BITS-1:0] head;
   logic            pop;
   logic            late_ev;
   logic            under_ev;
   logic [15:0]     ucnt_base;
   logic [15:0]     ucnt_next;

   Counter #(.M(RATE_DIV)) u_timer (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .co  (tick)
   );

   sync_fifo #(.WIDTH(BITS), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (s_valid),
      .wr_data (s_data),
      .rd_en   (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .level   (level)
   );

   assign s_ready = ~full;

   // A busy driver outranks everything else at a tick, even in IDLE.
   assign late_ev  = tick & ((state != IDLE) | dac_busy);
   assign pop      = tick & (state == IDLE) & ~dac_busy & ~empty;
   assign under_ev = tick & (state == IDLE) & ~dac_busy & empty;

   // A new event in the same cycle as clr_err survives the clear.
   assign ucnt_base = clr_err ? 16'd0 : underrun_cnt;
   assign ucnt_next = (under_ev && ucnt_base != UNDERRUN_MAX) ? ucnt_base + 16'd1 : ucnt_base;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         dac_start    <= 1'b0;
         dac_data     <= '0;
         underrun_cnt <= '0;
         late         <= 1'b0;
      end else begin
         dac_start    <= 1'b0;
         underrun_cnt <= ucnt_next;
         late         <= late_ev | (late & ~clr_err);
         case (state)
            IDLE: begin
               if (pop) begin
                  dac_data  <= head;
                  dac_start <= 1'b1;
                  state     <= START;
               end else if (under_ev && REPEAT_ON_UNDERRUN != 0) begin
                  dac_start <= 1'b1;
                  state     <= START;
               end
            end
            START: state <= WAIT;
            WAIT: begin
               if (!dac_busy)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_dac_sample_feeder.sv
// ---------------------------------------------------------------------------
// tb_dac_sample_feeder : directed scenarios plus random traffic vs. a queue model
// Revision             : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dac_sample_feeder;
   localparam int BITS     = 16;
   localparam int DEPTH    = 4;
   localparam int RATE_DIV = 40;
   localparam int LW       = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst, en, s_valid, clr_err, dac_busy;
   logic [BITS-1:0] s_data;
   logic            s_ready, dac_start, late;
   logic [LW-1:0]   level;
   logic [BITS-1:0] dac_data;
   logic [15:0]     underrun_cnt;

   logic            s_ready2, dac_start2, late2;
   logic [LW-1:0]   level2;
   logic [BITS-1:0] dac_data2;
   logic [15:0]     underrun_cnt2;

   dac_sample_feeder #(.BITS(BITS), .DEPTH(DEPTH), .RATE_DIV(RATE_DIV), .REPEAT_ON_UNDERRUN(1)) dut (
      .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .level(level), .dac_start(dac_start), .dac_data(dac_data), .dac_busy(dac_busy),
      .underrun_cnt(underrun_cnt), .late(late), .clr_err(clr_err)
   );

   // Second instance never receives data: every tick is an underrun and must be skipped.
   dac_sample_feeder #(.BITS(BITS), .DEPTH(DEPTH), .RATE_DIV(RATE_DIV), .REPEAT_ON_UNDERRUN(0)) dut_skip (
      .clk(clk), .rst(rst), .en(en), .s_data(16'h0000), .s_valid(1'b0), .s_ready(s_ready2),
      .level(level2), .dac_start(dac_start2), .dac_data(dac_data2), .dac_busy(1'b0),
      .underrun_cnt(underrun_cnt2), .late(late2), .clr_err(clr_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model state (values the DUT should show after the coming edge)
   logic [15:0] mq[$];
   int          m_tcnt = 0;
   int          m_stage = 0;   // 0 no frame, 1 start cycle, 2 frame in flight
   logic        m_start = 0, m_late = 0;
   logic [15:0] m_data = 0, m_ucnt = 0, m_u2 = 0;

   // Driver model and start log
   int          rem = 0, busy_len = 34, cyc = 0, max_level = 0;
   logic        prev_start = 0;
   int          st_time[$];
   logic [15:0] st_data[$];

   task automatic model_step();
      logic tick, push, late_ev, under_ev, go;
      if (rst) begin
         mq.delete();
         m_tcnt = 0; m_stage = 0; m_start = 0; m_data = 0;
         m_ucnt = 0; m_late = 0; m_u2 = 0;
         return;
      end
      tick = en && (m_tcnt == RATE_DIV - 1);
      push = s_valid && (mq.size() < DEPTH);
      late_ev = 0; under_ev = 0; go = 0;
      if (tick) begin
         if (m_stage != 0 || dac_busy) late_ev = 1;
         else if (mq.size() > 0) begin m_data = mq.pop_front(); go = 1; end
         else begin under_ev = 1; go = 1; end
      end
      m_start = go;
      if (go) m_stage = 1;
      else if (m_stage == 1) m_stage = 2;
      else if (m_stage == 2 && !dac_busy) m_stage = 0;
      if (push) mq.push_back(s_data);
      if (clr_err) begin m_late = 0; m_ucnt = 0; m_u2 = 0; end
      if (late_ev) m_late = 1;
      if (under_ev && m_ucnt != 16'hFFFF) m_ucnt++;
      if (tick && m_u2 != 16'hFFFF) m_u2++;
      m_tcnt = (!en || tick) ? 0 : m_tcnt + 1;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      check("level", level, mq.size());
      check("s_ready", s_ready, (mq.size() < DEPTH));
      check("dac_start", dac_start, m_start);
      check("dac_data", dac_data, m_data);
      check("underrun_cnt", underrun_cnt, m_ucnt);
      check("late", late, m_late);
      check("skip_ucnt", underrun_cnt2, m_u2);
      check("skip_start", dac_start2, 0);
      check("skip_late", late2, 0);
      check("skip_level", level2, 0);
      if (prev_start) rem = busy_len;
      else if (rem > 0) rem--;
      dac_busy   = (rem > 0);
      prev_start = dac_start;
      if (dac_start) begin st_time.push_back(cyc); st_data.push_back(dac_data); end
      if (int'(level) > max_level) max_level = int'(level);
   endtask

   task automatic wait_start(input string tag);
      int k = 0;
      do begin cycle(); k++; end while (!dac_start && k < 200);
      check(tag, dac_start, 1);
   endtask

   initial begin
      int n;
      logic ok;
      rst = 1; en = 0; s_valid = 0; s_data = 0; clr_err = 0; dac_busy = 0;
      repeat (2) cycle();
      check("rst_s_ready", s_ready, 1);
      check("rst_level", level, 0);
      check("rst_dac_start", dac_start, 0);
      check("rst_dac_data", dac_data, 0);
      check("rst_underrun", underrun_cnt, 0);
      check("rst_late", late, 0);
      rst = 0;

      // Two queued samples go out on consecutive ticks, one period apart
      s_valid = 1; s_data = 16'h1234; cycle();
      s_data = 16'hABCD; cycle();
      s_valid = 0; en = 1;
      n = st_time.size();
      repeat (100) cycle();
      check("t1_nstarts", st_time.size() - n, 2);
      if (st_time.size() >= n + 2) begin
         check("t1_first", st_data[n], 16'h1234);
         check("t1_second", st_data[n+1], 16'hABCD);
         check("t1_spacing", st_time[n+1] - st_time[n], RATE_DIV);
      end

      // Five back-to-back pushes: fifth waits for a pop
      wait_start("t2_sync");
      for (int i = 0; i < 5; i++) begin
         s_valid = 1; s_data = 16'h1000 + 16'(i); ok = 0;
         for (int k = 0; k < 100 && !ok; k++) begin ok = s_ready; cycle(); end
         check("t2_accept", ok, 1);
         if (i == 3) begin
            check("t2_full_ready", s_ready, 0);
            check("t2_level4", level, 4);
         end
      end
      s_valid = 0;

      // Drain, then an empty tick repeats the last sample
      for (int k = 0; k < 400 && level != 0; k++) cycle();
      check("t3_drained", level, 0);
      clr_err = 1; cycle(); clr_err = 0;
      wait_start("t3_repeat_start");
      check("t3_repeat_data", dac_data, 16'h1004);
      check("t3_underrun", underrun_cnt, 1);
      check("t3_skip_underrun", underrun_cnt2, 1);

      // A long frame makes the next tick late; clr_err clears it
      busy_len = 50;
      wait_start("t4_sync");
      cycle(); busy_len = 34;
      n = st_time.size();
      for (int k = 0; k < 100 && !late; k++) cycle();
      check("t4_late", late, 1);
      check("t4_no_start", st_time.size() - n, 0);
      clr_err = 1; cycle(); clr_err = 0;
      check("t4_cleared", late, 0);

      // Reset while a frame is in flight with samples queued
      wait_start("t5_sync");
      s_valid = 1;
      for (int i = 0; i < 3; i++) begin s_data = 16'h5500 + 16'(i); cycle(); end
      s_valid = 0; rst = 1; cycle(); rst = 0; en = 0;
      check("t5_level", level, 0);
      check("t5_start", dac_start, 0);
      check("t5_late", late, 0);
      n = st_time.size();
      repeat (80) cycle();
      check("t5_no_start", st_time.size() - n, 0);

      // Push and pop in the same cycle at level 2
      en = 1; s_valid = 1;
      s_data = 16'h00A1; cycle();
      s_data = 16'h00B2; cycle();
      s_valid = 0;
      for (int k = 0; k < RATE_DIV + 5 && m_tcnt != RATE_DIV - 1; k++) cycle();
      n = st_time.size();
      s_valid = 1; s_data = 16'h00C3; cycle(); s_valid = 0;
      check("t6_level", level, 2);
      repeat (130) cycle();
      check("t6_nstarts_ok", st_time.size() >= n + 3, 1);
      if (st_time.size() >= n + 3) begin
         check("t6_order0", st_data[n],   16'h00A1);
         check("t6_order1", st_data[n+1], 16'h00B2);
         check("t6_order2", st_data[n+2], 16'h00C3);
      end

      // Random traffic: bursty writes, pauses, clears, resets, varying frame length
      for (int k = 0; k < 2500; k++) begin
         en       = ($urandom_range(0, 99) < 95);
         s_valid  = ($urandom_range(0, 99) < (k < 1250 ? 60 : 3));
         s_data   = 16'($urandom);
         clr_err  = ($urandom_range(0, 99) < 2);
         rst      = ($urandom_range(0, 999) < 3);
         busy_len = $urandom_range(20, 50);
         cycle();
      end
      rst = 0; clr_err = 0; s_valid = 0;
      check("max_level_le_depth", (max_level <= DEPTH), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
